serial_adder: RTL and testbench
===============================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving operand width in bits (legal range 2..32).
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1; reset is asynchronous and active-high.
REQ-004 SHALL have port start, input, 1, the request to begin an addition; sampled only when ready=1.
REQ-005 SHALL have port a, input, WIDTH, the first operand; captured with start.
REQ-006 SHALL have port b, input, WIDTH, the second operand; captured with start.
REQ-007 SHALL have port cin, input, 1, the carry-in; captured with start.
REQ-008 SHALL have port ready, output, 1; 1 when a start will be accepted.
REQ-009 SHALL have port done, output, 1, a one-cycle pulse marking sum/cout valid.
REQ-010 SHALL have port sum, output, WIDTH, the result of a+b+cin modulo 2^WIDTH.
REQ-011 SHALL have port cout, output, 1, the carry-out of the full WIDTH-bit addition.

Function
REQ-012 SHALL implement states IDLE, RUN and DONE.
REQ-013 SHALL set ready=1 in IDLE and DONE and ready=0 in RUN.
REQ-014 SHALL set done=1 only in DONE.
REQ-015 On an edge with start=1 and ready=1, SHALL capture a and b into shift registers, capture cin into the carry register, clear the bit counter and enter RUN.
REQ-016 In RUN, each edge SHALL add the LSBs of the a and b shift registers plus the carry register in one single-bit full-adder stage.
REQ-017 In RUN, each edge SHALL load that stage's carry-out into the carry register, shift the stage's sum bit into the MSB of the sum register, shift the a and b registers right and increment the counter.
REQ-018 After exactly WIDTH RUN edges (counter = WIDTH-1 on the final edge), SHALL enter DONE.
REQ-019 Latency SHALL be fixed: start accepted at edge k gives done=1 in the cycle after edge k+WIDTH.
REQ-020 In DONE, sum SHALL equal (a+b+cin) mod 2^WIDTH and cout SHALL equal bit WIDTH of a+b+cin, using the captured operands.
REQ-021 From DONE, SHALL go to RUN on start=1 (back-to-back, no bubble), otherwise to IDLE.
REQ-022 SHALL hold sum and cout stable from DONE until the edge after the next accepted start.
REQ-023 SHALL ignore start in RUN with no effect on the operation in progress.
REQ-024 SHALL not let changes to a, b or cin after capture affect the result.
REQ-025 SHALL assign cout directly from the carry register; sum SHALL be the sum shift register.

Reset
REQ-026 While reset=1, regardless of clk, SHALL force state=IDLE, ready=1, done=0, sum=0, cout=0, counter=0 and operand/carry registers=0.
REQ-027 Reset asserted mid-RUN SHALL abandon the operation and produce no done pulse.
REQ-028 The first start SHALL be accepted on the first rising edge after reset deasserts.

Structure
REQ-029 SHALL take the state enum type and the default WIDTH constant from shared package serial_adder_pkg.
REQ-030 SHALL instantiate one sub-module, fa_stage (inputs a, b, cin; outputs sum, cout; purely combinational), as the per-bit adder.
REQ-031 SHALL size the counter at $clog2(WIDTH) bits and SHALL contain no other arithmetic.

Verification (WIDTH=8)
REQ-032 SHALL check a=0x5A, b=0x3C, cin=0 -> done in 9th cycle after start, sum=0x96, cout=0.
REQ-033 SHALL check a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; and a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
REQ-034 SHALL check a start pulse with a=0x11 during RUN of 0x5A+0x3C -> ignored, result 0x96, exactly one done pulse.
REQ-035 SHALL check reset asserted 3 cycles into RUN -> immediate IDLE, outputs 0, no done; a following 0x01+0x01 gives sum=0x02.
REQ-036 SHALL check start held high in DONE with new operands 0x80+0x80+0 -> RUN next cycle, previous result held until then, new result sum=0x00, cout=1.
REQ-037 SHALL compare every done result against a+b+cin in a random run of 1000 operations with random start gaps.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
package serial_adder_pkg;

   localparam int WIDTH_DEFAULT = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/serial_adder_fa_stage.sv
// Single-bit combinational full adder used as the serial adder's datapath.
module fa_stage (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);

   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder stage consumes an operand bit per clock,
// producing a WIDTH-bit sum and carry-out after WIDTH cycles.
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             ready,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   state_t           state_q, state_d;
   logic             ready_q, ready_d;
   logic             done_q, done_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             carry_q, carry_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic fa_sum;
   logic fa_cout;

   fa_stage u_fa (
      .a    (a_q[0]),
      .b    (b_q[0]),
      .cin  (carry_q),
      .sum  (fa_sum),
      .cout (fa_cout)
   );

   always_comb begin
      state_d = state_q;
      ready_d = ready_q;
      done_d  = 1'b0;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      cnt_d   = cnt_q;

      case (state_q)
         RUN: begin
            // Result bits enter at the MSB so the LSB lands at bit 0 after WIDTH shifts.
            carry_d = fa_cout;
            sum_d   = {fa_sum, sum_q[WIDTH-1:1]};
            a_d     = {1'b0, a_q[WIDTH-1:1]};
            b_d     = {1'b0, b_q[WIDTH-1:1]};
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) begin
               state_d = DONE;
               ready_d = 1'b1;
               done_d  = 1'b1;
            end else begin
               ready_d = 1'b0;
            end
         end
         default: begin
            // Previous sum/cout stay put until a new operation is captured.
            if (start && ready_q) begin
               state_d = RUN;
               ready_d = 1'b0;
               a_d     = a;
               b_d     = b;
               carry_d = cin;
               cnt_d   = '0;
            end else begin
               state_d = IDLE;
               ready_d = 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         ready_q <= 1'b1;
         done_q  <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         ready_q <= ready_d;
         done_q  <= done_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         cnt_q   <= cnt_d;
      end
   end

   assign ready = ready_q;
   assign done  = done_q;
   assign sum   = sum_q;
   assign cout  = carry_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8) using a cycle-count model
// of a+b+cin plus directed vectors with literal expectations.
module tb_serial_adder;

   localparam int W = 8;

   logic         clk;
   logic         reset;
   logic         start;
   logic [W-1:0] a_i;
   logic [W-1:0] b_i;
   logic         cin_i;
   logic         ready;
   logic         done;
   logic [W-1:0] sum;
   logic         cout;

   int checks   = 0;
   int failures = 0;
   bit chk_en   = 1'b0;

   serial_adder #(.WIDTH(W)) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .a     (a_i),
      .b     (b_i),
      .cin   (cin_i),
      .ready (ready),
      .done  (done),
      .sum   (sum),
      .cout  (cout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: an accepted start makes the result appear WIDTH edges later.
   int           m_busy;
   bit           m_ready;
   bit           m_done;
   logic [W-1:0] m_sum;
   bit           m_cout;
   logic [W:0]   m_pend;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_busy  = 0;
         m_ready = 1'b1;
         m_done  = 1'b0;
         m_sum   = '0;
         m_cout  = 1'b0;
      end else if (m_busy > 0) begin
         m_busy--;
         if (m_busy == 0) begin
            m_done  = 1'b1;
            m_ready = 1'b1;
            {m_cout, m_sum} = m_pend;
         end
      end else begin
         m_done = 1'b0;
         if (start) begin
            m_pend  = {1'b0, a_i} + {1'b0, b_i} + {{W{1'b0}}, cin_i};
            m_busy  = W;
            m_ready = 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en && !reset) begin
         check("ready", 32'(ready), 32'(m_ready));
         check("done", 32'(done), 32'(m_done));
         if (m_ready) begin
            check("sum_hold", 32'(sum), 32'(m_sum));
            check("cout_hold", 32'(cout), 32'(m_cout));
         end
      end
   end

   task automatic start_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv);
      a_i   = av;
      b_i   = bv;
      cin_i = cv;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic wait_done(output int lat);
      lat = 0;
      for (int j = 1; j <= 20; j++) begin
         @(negedge clk);
         if (done) begin
            lat = j;
            break;
         end
      end
      if (lat == 0) begin
         failures++;
         checks++;
         $display("FAIL done_timeout: got no done within 20 cycles expected a pulse");
      end
   endtask

   task automatic run_op(input string name, input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic cv, input logic [W-1:0] es, input logic ec);
      int lat;
      start_op(av, bv, cv);
      wait_done(lat);
      check({name, "_latency"}, 32'(lat), 32'(W + 1));
      check({name, "_sum"}, 32'(sum), 32'(es));
      check({name, "_cout"}, 32'(cout), 32'(ec));
      check({name, "_model"}, 32'({m_cout, m_sum}), 32'({ec, es}));
   endtask

   initial begin
      int lat;
      int npulse;
      logic [W-1:0] seen_sum;
      int gap;

      reset = 1'b1;
      start = 1'b0;
      a_i   = '0;
      b_i   = '0;
      cin_i = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_ready", 32'(ready), 32'd1);
      check("rst_done", 32'(done), 32'd0);
      check("rst_sum", 32'(sum), 32'd0);
      check("rst_cout", 32'(cout), 32'd0);
      reset  = 1'b0;
      chk_en = 1'b1;

      run_op("add_5a_3c", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0);
      @(negedge clk);
      run_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
      @(negedge clk);
      run_op("add_ff_ff_1", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
      @(negedge clk);

      // Start pulse during RUN must be ignored.
      start_op(8'h5A, 8'h3C, 1'b0);
      repeat (3) @(negedge clk);
      start_op(8'h11, 8'h22, 1'b1);
      npulse   = 0;
      seen_sum = '0;
      for (int j = 0; j < 16; j++) begin
         @(negedge clk);
         if (done) begin
            npulse++;
            seen_sum = sum;
         end
      end
      check("ignore_pulses", 32'(npulse), 32'd1);
      check("ignore_sum", 32'(seen_sum), 32'h96);

      // Reset three cycles into RUN.
      @(negedge clk);
      start_op(8'h7F, 8'h7F, 1'b1);
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      #1;
      check("midrst_ready", 32'(ready), 32'd1);
      check("midrst_done", 32'(done), 32'd0);
      check("midrst_sum", 32'(sum), 32'd0);
      check("midrst_cout", 32'(cout), 32'd0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      run_op("after_rst", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0);

      // Back-to-back start held in DONE.
      @(negedge clk);
      start_op(8'h5A, 8'h3C, 1'b0);
      wait_done(lat);
      a_i   = 8'h80;
      b_i   = 8'h80;
      cin_i = 1'b0;
      start = 1'b1;
      check("b2b_prev_sum", 32'(sum), 32'h96);
      check("b2b_prev_cout", 32'(cout), 32'd0);
      @(posedge clk);
      #1 start = 1'b0;
      check("b2b_run_ready", 32'(ready), 32'd0);
      wait_done(lat);
      check("b2b_latency", 32'(lat), 32'(W + 1));
      check("b2b_sum", 32'(sum), 32'h00);
      check("b2b_cout", 32'(cout), 32'd1);

      // Random operations with random gaps and noise on inputs during RUN.
      @(negedge clk);
      for (int n = 0; n < 1000; n++) begin
         a_i   = W'($urandom);
         b_i   = W'($urandom);
         cin_i = 1'($urandom);
         start = 1'b1;
         @(posedge clk);
         #1;
         lat = 0;
         for (int j = 1; j <= 20; j++) begin
            @(negedge clk);
            if (done) begin
               lat = j;
               break;
            end
            start = 1'($urandom);
            a_i   = W'($urandom);
            b_i   = W'($urandom);
            cin_i = 1'($urandom);
         end
         check("rand_latency", 32'(lat), 32'(W + 1));
         gap = $urandom_range(0, 3);
         if (gap != 0) begin
            start = 1'b0;
            repeat (gap) @(negedge clk);
         end
      end
      start = 1'b0;
      repeat (3) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
